// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Control FSM for a one-round-per-cycle AES-128 core. On an accepted start it
//   steps the core through the initial AddRoundKey, rounds 1..NR-1 and the final
//   round. It then pulses ok to the byte-serialising output interface and waits
//   for that interface to drain before it accepts new work.
//
// Parameters
//   NR            total cipher rounds (2..15)
//   DRAIN_TIMEOUT cycles allowed across both drain states before giving up
//
// Ports
//   clk        system clock, rising edge
//   rst_       synchronous reset, active HIGH despite the suffix
//   start      encrypt request, sampled only in IDLE
//   out_ready  output interface ready (1 = previous cipher fully shifted out)
//   in_ready   1 only in IDLE
//   busy       1 in every state except IDLE
//   load_state core loads plaintext^key and key (round 0)
//   round_en   core performs one round this cycle
//   mix_en     include MixColumns (0 in the final round)
//   round      current round index 0..NR
//   rcon       key-expansion round constant, 0x00 when round_en=0
//   ok         one-cycle pulse, cipher valid on the core output
//   err        sticky drain-timeout flag, cleared by reset or accepted start

module aes_round_sequencer #(
    parameter int NR            = 10,
    parameter int DRAIN_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       start,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       busy,
    output logic       load_state,
    output logic       round_en,
    output logic       mix_en,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       ok,
    output logic       err
);

    localparam int             CW       = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]     R_LAST   = 4'(NR - 1);
    localparam logic [3:0]     R_FINAL  = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE,
        S_DRAIN_LO,
        S_DRAIN_HI
    } state_t;

    state_t        state;
    logic [CW-1:0] drain_cnt;

    // GF(2^8) multiply by x: next round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Outputs are assigned together with the next state so every output is
    // registered and reflects the state the FSM is entering.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            load_state <= 1'b0;
            round_en   <= 1'b0;
            mix_en     <= 1'b0;
            round      <= '0;
            rcon       <= '0;
            ok         <= 1'b0;
            err        <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    drain_cnt <= '0;
                    if (start) begin
                        state      <= S_INIT;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        load_state <= 1'b1;
                        err        <= 1'b0;
                    end
                end

                S_INIT: begin
                    state      <= S_ROUND;
                    load_state <= 1'b0;
                    round_en   <= 1'b1;
                    mix_en     <= 1'b1;
                    round      <= 4'd1;
                    rcon       <= 8'h01;
                end

                S_ROUND: begin
                    rcon <= xtime(rcon);
                    if (round == R_LAST) begin
                        state  <= S_FINAL;
                        round  <= R_FINAL;
                        mix_en <= 1'b0;
                    end else begin
                        round <= round + 4'd1;
                    end
                end

                S_FINAL: begin
                    state    <= S_DONE;
                    round_en <= 1'b0;
                    rcon     <= '0;
                    ok       <= 1'b1;
                end

                S_DONE: begin
                    state     <= S_DRAIN_LO;
                    ok        <= 1'b0;
                    drain_cnt <= '0;
                end

                // out_ready low acknowledges ok; the timer spans both drain states.
                S_DRAIN_LO: begin
                    if (drain_cnt == CNT_LAST) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        round    <= '0;
                        err      <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                        if (!out_ready) begin
                            state <= S_DRAIN_HI;
                        end
                    end
                end

                // A normal exit on the last timer cycle wins over the timeout.
                S_DRAIN_HI: begin
                    if (out_ready) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        round    <= '0;
                    end else if (drain_cnt == CNT_LAST) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        round    <= '0;
                        err      <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    in_ready   <= 1'b1;
                    busy       <= 1'b0;
                    load_state <= 1'b0;
                    round_en   <= 1'b0;
                    mix_en     <= 1'b0;
                    round      <= '0;
                    rcon       <= '0;
                    ok         <= 1'b0;
                end
            endcase
        end
    end

endmodule
